// File: rtl/marker_locator.sv
// Scans one RGB frame and reports the bounding-box centre of red marker pixels
// found in each of the four screen quadrants.
module marker_locator #(
    parameter int         H_ACT  = 800,
    parameter int         V_ACT  = 600,
    parameter logic [9:0] THR_HI = 10'd768,
    parameter logic [9:0] THR_LO = 10'd256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_frame_start,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    output logic        o_addr_valid,
    output logic [19:0] o_ul_addr,
    output logic [19:0] o_ur_addr,
    output logic [19:0] o_dl_addr,
    output logic [19:0] o_dr_addr,
    output logic [3:0]  o_found,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic [9:0] ROW_LAST = 10'(V_ACT - 1);
    localparam logic [9:0] COL_LAST = 10'(H_ACT - 1);
    localparam logic [9:0] ROW_HALF = 10'(V_ACT / 2);
    localparam logic [9:0] COL_HALF = 10'(H_ACT / 2);

    state_t            state_q, state_d;
    logic [9:0]        row_q, row_d, col_q, col_d;
    // Box index 0..3 = UL, UR, DL, DR
    logic [3:0][9:0]   rmin_q, rmin_d, rmax_q, rmax_d;
    logic [3:0][9:0]   cmin_q, cmin_d, cmax_q, cmax_d;
    logic [3:0]        nz_q, nz_d;
    logic [3:0][19:0]  addr_q, addr_d;
    logic [3:0]        found_q, found_d;
    logic              av_q, av_d;

    logic [3:0][10:0]  rsum, csum;
    logic [3:0][19:0]  mid;
    logic [1:0]        qd;
    logic              is_mark, last_px;
    logic              unused_top;

    assign unused_top = ^i_data[31:30];
    assign is_mark = (i_data[29:20] >= THR_HI) && (i_data[19:10] < THR_LO)
                  && (i_data[9:0] < THR_LO);
    assign qd      = {row_q >= ROW_HALF, col_q >= COL_HALF};
    assign last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);

    for (genvar k = 0; k < 4; k++) begin : g_mid
        assign rsum[k] = {1'b0, rmin_q[k]} + {1'b0, rmax_q[k]};
        assign csum[k] = {1'b0, cmin_q[k]} + {1'b0, cmax_q[k]};
        assign mid[k]  = {rsum[k][10:1], csum[k][10:1]};
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rmin_d  = rmin_q;
        rmax_d  = rmax_q;
        cmin_d  = cmin_q;
        cmax_d  = cmax_q;
        nz_d    = nz_q;
        addr_d  = addr_q;
        found_d = found_q;
        av_d    = 1'b0;
        case (state_q)
            SCAN: begin
                if (!i_frame_start && i_valid) begin
                    if (is_mark && !nz_q[qd]) begin
                        rmin_d[qd] = row_q;
                        rmax_d[qd] = row_q;
                        cmin_d[qd] = col_q;
                        cmax_d[qd] = col_q;
                        nz_d[qd]   = 1'b1;
                    end else if (is_mark) begin
                        if (row_q < rmin_q[qd]) rmin_d[qd] = row_q;
                        if (row_q > rmax_q[qd]) rmax_d[qd] = row_q;
                        if (col_q < cmin_q[qd]) cmin_d[qd] = col_q;
                        if (col_q > cmax_q[qd]) cmax_d[qd] = col_q;
                    end
                    if (last_px) begin
                        state_d = REPORT;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 10'd1;
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end
            REPORT: begin
                av_d    = 1'b1;
                found_d = {nz_q[0], nz_q[1], nz_q[2], nz_q[3]};
                for (int k = 0; k < 4; k++)
                    if (nz_q[k]) addr_d[k] = mid[k];
                state_d = IDLE;
            end
            default: ;
        endcase
        // A frame start restarts the scan from any state, after any report above.
        if (i_frame_start) begin
            state_d = SCAN;
            row_d   = '0;
            col_d   = '0;
            nz_d    = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            rmin_q  <= '0;
            rmax_q  <= '0;
            cmin_q  <= '0;
            cmax_q  <= '0;
            nz_q    <= '0;
            addr_q  <= '0;
            found_q <= '0;
            av_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rmin_q  <= rmin_d;
            rmax_q  <= rmax_d;
            cmin_q  <= cmin_d;
            cmax_q  <= cmax_d;
            nz_q    <= nz_d;
            addr_q  <= addr_d;
            found_q <= found_d;
            av_q    <= av_d;
        end
    end

    assign o_addr_valid = av_q;
    assign o_ul_addr    = addr_q[0];
    assign o_ur_addr    = addr_q[1];
    assign o_dl_addr    = addr_q[2];
    assign o_dr_addr    = addr_q[3];
    assign o_found      = found_q;
    assign o_busy       = (state_q == SCAN);
endmodule

// File: tb/tb_marker_locator.sv
// Randomized frame bench for marker_locator on a reduced 64x48 frame, checked
// every cycle against a marker-list model plus a log of literal report values.
module tb_marker_locator;
    localparam int H = 64, V = 48;
    localparam logic [9:0] HI = 10'd768, LO = 10'd256;

    logic        i_clk = 0, i_rst = 0, i_frame_start = 0, i_valid = 0;
    logic [31:0] i_data = 0;
    logic        o_addr_valid, o_busy;
    logic [19:0] o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr;
    logic [3:0]  o_found;

    marker_locator #(.H_ACT(H), .V_ACT(V), .THR_HI(HI), .THR_LO(LO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start),
        .i_valid(i_valid), .i_data(i_data), .o_addr_valid(o_addr_valid),
        .o_ul_addr(o_ul_addr), .o_ur_addr(o_ur_addr), .o_dl_addr(o_dl_addr),
        .o_dr_addr(o_dr_addr), .o_found(o_found), .o_busy(o_busy));

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int npass = 0, nchk = 0;

    typedef struct { int r0, r1, c0, c1; } rect_t;
    typedef struct packed { logic [3:0][19:0] a; logic [3:0] f; } rep_t;
    rect_t rects[$];
    rep_t  lg[$];

    // model state
    bit               active = 0, rep_pend = 0;
    int               n = 0, av_cyc = -1;
    int               mr[$], mc[$];
    logic [3:0][19:0] e_addr = '0;
    logic [3:0]       e_found = '0;

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    endtask

    function automatic logic [19:0] A(int r, int c);
        return {10'(r), 10'(c)};
    endfunction

    function automatic bit is_mk(logic [31:0] d);
        return d[29:20] >= HI && d[19:10] < LO && d[9:0] < LO;
    endfunction

    function automatic logic [31:0] bgpix();
        logic [9:0] r, g, b;
        r = 10'($urandom); g = 10'($urandom); b = 10'($urandom);
        case ($urandom_range(0, 5))
            0: r = 10'($urandom_range(0, 767));
            1: g = 10'($urandom_range(256, 1023));
            2: b = 10'($urandom_range(256, 1023));
            3: begin r = 10'd767; g = 0; b = 0; end
            4: begin r = 10'd1023; g = 10'd256; b = 10'd255; end
            default: begin r = 0; g = 0; b = 0; end
        endcase
        return {2'b0, r, g, b};
    endfunction

    function automatic logic [31:0] mkpix();
        if ($urandom_range(0, 3) == 0) return {2'b0, 10'd768, 10'd255, 10'd255};
        return {2'b0, 10'($urandom_range(768, 1023)), 10'($urandom_range(0, 255)),
                10'($urandom_range(0, 255))};
    endfunction

    // Quadrant index 0..3 = UL, UR, DL, DR
    function automatic int quad(int r, int c);
        return (r >= V / 2 ? 2 : 0) + (c >= H / 2 ? 1 : 0);
    endfunction

    task automatic do_report();
        e_found = '0;
        for (int q = 0; q < 4; q++) begin
            int r0 = 9999, r1 = -1, c0 = 9999, c1 = -1;
            for (int i = 0; i < mr.size(); i++)
                if (quad(mr[i], mc[i]) == q) begin
                    if (mr[i] < r0) r0 = mr[i];
                    if (mr[i] > r1) r1 = mr[i];
                    if (mc[i] < c0) c0 = mc[i];
                    if (mc[i] > c1) c1 = mc[i];
                end
            if (r1 >= 0) begin
                e_addr[q] = A((r0 + r1) / 2, (c0 + c1) / 2);
                e_found[3 - q] = 1'b1;
            end
        end
    endtask

    // Applies the effect of the clock edge that just consumed (fs, v, d).
    task automatic model_step(bit fs, bit v, logic [31:0] d);
        if (rep_pend) begin
            do_report();
            av_cyc = cyc;
            rep_pend = 0;
        end
        if (fs) begin
            active = 1; n = 0; mr.delete(); mc.delete();
        end else if (active && v) begin
            if (is_mk(d)) begin mr.push_back(n / H); mc.push_back(n % H); end
            n++;
            if (n == H * V) begin active = 0; rep_pend = 1; end
        end
    endtask

    task automatic drive(bit fs, bit v, logic [31:0] d);
        i_frame_start = fs; i_valid = v; i_data = d;
        @(posedge i_clk); #1;
        model_step(fs, v, d);
        i_frame_start = 0; i_valid = 0;
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) drive(0, 1'($urandom), mkpix());
    endtask

    task automatic send_frame(bit duty, int stop_at);
        drive(1, 1'($urandom), mkpix());
        for (int p = 0; p < stop_at; p++) begin
            int r = p / H, c = p % H;
            bit mk = 0;
            foreach (rects[j])
                if (r >= rects[j].r0 && r <= rects[j].r1 && c >= rects[j].c0 && c <= rects[j].c1)
                    mk = 1;
            if (duty) while ($urandom_range(0, 1) == 1) drive(0, 0, mkpix());
            drive(0, 1, mk ? mkpix() : bgpix());
        end
    endtask

    task automatic set_quad_blocks();
        rects = '{'{5, 8, 6, 9}, '{5, 8, 50, 53}, '{30, 33, 6, 9}, '{30, 33, 50, 53}};
    endtask

    task automatic set_edges();
        rects = '{'{0, 0, 0, 0}, '{47, 47, 63, 63}, '{23, 23, 31, 31},
                  '{24, 24, 32, 32}, '{23, 23, 32, 32}, '{24, 24, 31, 31}};
    endtask

    task automatic do_reset();
        @(posedge i_clk); #3;
        i_rst = 1;
        active = 0; rep_pend = 0; av_cyc = -1; e_addr = '0; e_found = '0;
        #1;
        check("rst_av", o_addr_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_found", o_found, 0);
        check("rst_addrs", {o_ul_addr | o_ur_addr | o_dl_addr | o_dr_addr}, 0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 0;
    endtask

    always @(negedge i_clk) begin
        check("addr_valid", o_addr_valid, cyc == av_cyc);
        check("busy", o_busy, active);
        check("found", o_found, e_found);
        check("ul_addr", o_ul_addr, e_addr[0]);
        check("ur_addr", o_ur_addr, e_addr[1]);
        check("dl_addr", o_dl_addr, e_addr[2]);
        check("dr_addr", o_dr_addr, e_addr[3]);
        if (o_addr_valid) lg.push_back('{a: {o_dr_addr, o_dl_addr, o_ur_addr, o_ul_addr}, f: o_found});
    end

    task automatic chk_rep(int i, logic [19:0] ul, logic [19:0] ur, logic [19:0] dl,
                           logic [19:0] dr, logic [3:0] f);
        rep_t x = '0;
        if (i < lg.size()) x = lg[i];
        check($sformatf("rep%0d_found", i), x.f, f);
        check($sformatf("rep%0d_ul", i), x.a[0], ul);
        check($sformatf("rep%0d_ur", i), x.a[1], ur);
        check($sformatf("rep%0d_dl", i), x.a[2], dl);
        check($sformatf("rep%0d_dr", i), x.a[3], dr);
    endtask

    initial begin
        #1 i_rst = 1;
        #1;
        check("init_found", o_found, 0);
        check("init_busy", o_busy, 0);
        check("init_addr", o_ul_addr, 0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 0;
        idle(5);

        rects = '{'{10, 10, 20, 20}};
        send_frame(0, H * V); idle(4);            // single UL marker
        set_quad_blocks();
        send_frame(0, H * V);                     // four blocks
        rects = '{'{2, 2, 40, 40}};
        send_frame(0, H * V); idle(4);            // frame start lands on REPORT cycle
        set_quad_blocks();
        send_frame(1, H * V);                     // 50% valid duty
        set_edges();
        send_frame(0, H * V); idle(4);            // quadrant boundaries, first/last pixel
        rects = '{'{1, 1, 1, 1}};
        send_frame(0, 1000);                      // abandoned frame
        rects = '{'{40, 40, 60, 60}};
        send_frame(0, H * V); idle(4);
        set_quad_blocks();
        send_frame(0, 500);
        do_reset();
        idle(300);
        set_edges();
        send_frame(1, H * V); idle(4);

        check("report_count", lg.size(), 7);
        chk_rep(0, A(10, 20), 0, 0, 0, 4'b1000);
        chk_rep(1, A(6, 7), A(6, 51), A(31, 7), A(31, 51), 4'b1111);
        chk_rep(2, A(6, 7), A(2, 40), A(31, 7), A(31, 51), 4'b0100);
        chk_rep(3, A(6, 7), A(6, 51), A(31, 7), A(31, 51), 4'b1111);
        chk_rep(4, A(11, 15), A(23, 32), A(24, 31), A(35, 47), 4'b1111);
        chk_rep(5, A(11, 15), A(23, 32), A(24, 31), A(40, 60), 4'b0001);
        chk_rep(6, A(11, 15), A(23, 32), A(24, 31), A(35, 47), 4'b1111);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/marker_locator.md
MARKER_LOCATOR -- requirements
Module: Marker_Locator

Interface
REQ-001 SHALL have parameters: H_ACT, 800, active columns per row; V_ACT, 600, active rows per frame; THR_HI, 10'd768, minimum R for a marker pixel; THR_LO, 10'd256, exclusive upper bound on G and B for a marker pixel.
REQ-002 SHALL have ports: i_clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have: i_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have: i_frame_start  in  1  one-cycle pulse, next accepted pixel is (row 0, col 0).
REQ-005 SHALL have: i_valid  in  1  pixel present on i_data this cycle.
REQ-006 SHALL have: i_data  in  32  pixel {2'b0, R[9:0], G[9:0], B[9:0]}.
REQ-007 SHALL have: o_addr_valid  out  1  one-cycle pulse, corner addresses updated.
REQ-008 SHALL have: o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr  out  20 each  marker centre {row[9:0], col[9:0]}.
REQ-009 SHALL have: o_found  out  4  {ul, ur, dl, dr}, marker seen in that quadrant last frame.
REQ-010 SHALL have: o_busy  out  1  high while in SCAN.

Function
REQ-011 SHALL implement FSM IDLE -> SCAN -> REPORT -> IDLE; reset state IDLE.
REQ-012 IDLE: i_frame_start -> SCAN; row/col counters cleared to 0; all four bounding boxes cleared to empty.
REQ-013 SCAN: each cycle with i_valid=1 accepts one pixel at (row, col), then col+1; at col H_ACT-1, col wraps to 0 and row+1.
REQ-014 Pixels with i_valid=0 SHALL be ignored; counters hold; no timeout.
REQ-015 Marker pixel: R >= THR_HI AND G < THR_LO AND B < THR_LO (unsigned compares).
REQ-016 Quadrant: UL row<V_ACT/2, col<H_ACT/2; UR row<V_ACT/2, col>=H_ACT/2; DL row>=V_ACT/2, col<H_ACT/2; DR remainder.
REQ-017 Per quadrant, a marker pixel SHALL update min_row, max_row, min_col, max_col; first marker pixel in an empty box loads all four with its coordinates and sets that box non-empty.
REQ-018 Sampling pixel (V_ACT-1, H_ACT-1) SHALL move FSM to REPORT on that same edge.
REQ-019 REPORT lasts exactly one cycle; at its closing edge: o_addr_valid<=1 for one cycle; for each non-empty box, addr <= {(min_row+max_row)>>1, (min_col+max_col)>>1}, sums 11 bits wide, low 10 bits of shifted result kept; o_found bit <= non-empty flag.
REQ-020 Empty quadrant: address output SHALL hold previous value; its o_found bit SHALL be 0.
REQ-021 Latency: o_addr_valid high in the second cycle after the last pixel's sampling edge; all address outputs stable from that cycle until the next report.
REQ-022 i_frame_start during SCAN SHALL abandon the frame: counters and boxes cleared, stay in SCAN, no report.
REQ-023 i_frame_start in the same cycle as REPORT SHALL be honoured: report issued, FSM goes to SCAN with cleared state instead of IDLE.
REQ-024 i_frame_start with i_valid=1 in the same cycle: the pixel SHALL be discarded; counting starts with the next valid pixel.
REQ-025 Pixels arriving in IDLE or REPORT (without frame start) SHALL be ignored.
REQ-026 o_busy SHALL be 1 exactly while state is SCAN.

Reset
REQ-027 i_rst=1 SHALL immediately force: state IDLE, counters 0, boxes empty, o_addr_valid 0, all addresses 20'h0, o_found 4'b0, o_busy 0.
REQ-028 Reset mid-SCAN SHALL discard the partial frame; no o_addr_valid until a new frame start plus a complete frame.

Verification
REQ-029 Full frame, single marker pixel (100,200) in UL, all else black -> one o_addr_valid; o_ul_addr={10'd100,10'd200}; o_found=4'b1000; other addrs 0.
REQ-030 4x4 red blocks in all quadrants at rows 50-53/cols 60-63, 50-53/700-703, 500-503/60-63, 500-503/700-703 -> centres (51,61), (51,701), (501,61), (501,701); o_found=4'b1111.
REQ-031 Second frame containing only a UR marker after REQ-030 -> o_found=4'b0100; UL, DL, DR addrs keep frame-1 values.
REQ-032 i_valid toggled randomly at 50% duty over a full frame -> same result as REQ-030; o_addr_valid exactly 2 cycles after the last pixel edge.
REQ-033 i_frame_start at pixel 1000, then full frame -> only one report, reflecting the second frame only.
REQ-034 i_rst pulsed mid-frame -> all outputs 0 immediately; no report until a new full frame.
